// File: rtl/seg_pkg.sv
// seg_pkg: segment patterns, blank pattern, dp bit position and slot phase enum
// shared by the seven-segment scan driver.
package seg_pkg;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam int DP_BIT = 0;
    // Active-low {a,b,c,d,e,f,g,dp} patterns for hex 0..F, dp left dark.
    localparam logic [7:0] SEG_TAB [16] = '{
        8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
        8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
        8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
        8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001
    };
    typedef enum logic {BLANK, SHOW} state_t;
endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: datapath-side inputs and display pins of the scan driver;
// master = value producer, slave = the driver.
interface seg_scan_driver_if #(parameter int N_DIGITS = 4);
    logic                    enable;
    logic [4*N_DIGITS-1:0]   value;
    logic [N_DIGITS-1:0]     dp;
    logic                    load;
    logic [7:0]              display_pins;
    logic [N_DIGITS-1:0]     digit_sel;
    logic                    frame_start;
    modport master (output enable, value, dp, load, input display_pins, digit_sel, frame_start);
    modport slave (input enable, value, dp, load, output display_pins, digit_sel, frame_start);
endinterface

// File: rtl/seg_decode.sv
// seg_decode: hex nibble plus decimal point to active-low segment pattern.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    output logic [7:0] pat
);
    assign pat = SEG_TAB[nib] & ~(8'(dp) << DP_BIT);
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed common-anode display scanner with tear-free shadow.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN hides leading zero digits.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input logic clk,
    input logic rst_n,
    seg_scan_driver_if.slave bus
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam state_t RST_STATE = BLANK_CYCLES > 0 ? BLANK : SHOW;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    state_t                state, state_nxt;
    logic [4*N_DIGITS-1:0] pend_val, shad_val;
    logic [N_DIGITS-1:0]   pend_dp, shad_dp, sel_nxt;
    logic                  pend_vld, slot_end, wrap, commit, show, hide, fs_nxt;
    logic [3:0]            nib;
    logic [7:0]            pat, pins_nxt;
    seg_decode u_dec (.nib(nib), .dp(shad_dp[idx]), .pat(pat));
`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic run;
    // A digit is a leading zero when it and every digit above it are 0 with dp dark.
    always_comb begin
        hide = 1'b0;
        run  = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            run = run && shad_val[4*i +: 4] == 4'h0 && !shad_dp[i];
            if (idx == IW'(i)) hide = run;
        end
    end
`else
    assign hide = 1'b0;
`endif
    always_comb begin
        slot_end  = cnt == CW'(CLK_DIV - 1);
        wrap      = slot_end && idx == IW'(N_DIGITS - 1);
        commit    = !bus.enable || wrap;
        cnt_nxt   = (!bus.enable || slot_end) ? '0 : cnt + 1'b1;
        idx_nxt   = (!bus.enable || wrap) ? '0 : slot_end ? idx + 1'b1 : idx;
        state_nxt = cnt_nxt < CW'(BLANK_CYCLES) ? BLANK : SHOW;
        nib       = shad_val[4*idx +: 4];
        show      = bus.enable && state == SHOW && !hide;
        sel_nxt   = '1;
        if (show) sel_nxt[idx] = 1'b0;
        pins_nxt  = show ? pat : SEG_OFF;
        fs_nxt    = bus.enable && cnt == '0 && idx == '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt              <= '0;
            idx              <= '0;
            state            <= RST_STATE;
            pend_val         <= '0;
            pend_dp          <= '0;
            pend_vld         <= 1'b0;
            shad_val         <= '0;
            shad_dp          <= '0;
            bus.display_pins <= SEG_OFF;
            bus.digit_sel    <= '1;
            bus.frame_start  <= 1'b0;
        end else begin
            cnt              <= cnt_nxt;
            idx              <= idx_nxt;
            state            <= state_nxt;
            bus.display_pins <= pins_nxt;
            bus.digit_sel    <= sel_nxt;
            bus.frame_start  <= fs_nxt;
            if (bus.load) begin
                pend_val <= bus.value;
                pend_dp  <= bus.dp;
            end
            pend_vld <= !commit && (bus.load || pend_vld);
            // Shadow only changes between frames (or while dark), a same-cycle load wins.
            if (commit && bus.load) {shad_val, shad_dp} <= {bus.value, bus.dp};
            else if (commit && pend_vld) {shad_val, shad_dp} <= {pend_val, pend_dp};
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed checks of the scan driver with 4 digits,
// 8-cycle slots and a 2-cycle blanking gap.
module tb_seg_scan_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int vecs = 0;
    int errs = 0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [7:0] SEG [16] = '{
        8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
        8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
        8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
        8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001
    };
    localparam logic [12:0] ALL_OFF = {4'hF, 8'hFF, 1'b0};

    seg_scan_driver_if #(.N_DIGITS(4)) bus ();
    seg_scan_driver #(.N_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic logic lead_zero(int dg, logic [15:0] v, logic [3:0] d);
        logic z = 1'b1;
        for (int j = dg; j < 4; j++) if (v[4*j +: 4] != 4'h0 || d[j]) z = 1'b0;
        return LZB && dg != 0 && z;
    endfunction

    // Expected {digit_sel, display_pins, frame_start} at frame position p.
    function automatic logic [12:0] expect_at(int p, logic [15:0] v, logic [3:0] d);
        int dg = (p / 8) % 4;
        logic fs = (p % 32) == 0;
        if (p % 8 < 2 || lead_zero(dg, v, d)) return {4'hF, 8'hFF, fs};
        return {~(4'b0001 << dg), SEG[v[4*dg +: 4]] & ~{7'b0, d[dg]}, fs};
    endfunction

    function automatic logic [12:0] observed();
        return {bus.digit_sel, bus.display_pins, bus.frame_start};
    endfunction

    task automatic test_reset;
        logic [12:0] got;
        bus.enable = 1'b0; bus.load = 1'b0; bus.value = '0; bus.dp = '0;
        #1 rst_n = 1'b0;
        #2 got = observed();
        vecs++;
        if (got !== ALL_OFF) begin errs++; $display("FAIL reset got %b required %b", got, ALL_OFF); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        got = observed();
        vecs++;
        if (got !== ALL_OFF) begin errs++; $display("FAIL dark_after_reset got %b required %b", got, ALL_OFF); end
    endtask

    task automatic test_scan;
        logic [12:0] got, exp;
        bus.value = 16'h1234; bus.load = 1'b1;
        tick();
        bus.load = 1'b0; bus.enable = 1'b1;
        for (int p = 0; p < 64; p++) begin
            tick();
            got = observed(); exp = expect_at(p, 16'h1234, 4'h0);
            vecs++;
            if (got !== exp) begin errs++; $display("FAIL scan p=%0d got %b required %b", p, got, exp); end
        end
    endtask

    task automatic test_tear_free;
        logic [12:0] got, exp;
        for (int q = 0; q < 64; q++) begin
            if (q == 18) begin bus.value = 16'h9999; bus.load = 1'b1; end
            if (q == 19) bus.load = 1'b0;
            if (q == 20) begin bus.value = 16'hABCD; bus.load = 1'b1; end
            if (q == 21) begin bus.value = 16'h5555; bus.load = 1'b0; end
            tick();
            got = observed(); exp = expect_at(q, q < 32 ? 16'h1234 : 16'hABCD, 4'h0);
            vecs++;
            if (got !== exp) begin errs++; $display("FAIL tear_free q=%0d got %b required %b", q, got, exp); end
        end
    endtask

    task automatic test_dp_wrap_load;
        logic [12:0] got, exp;
        for (int q = 0; q < 64; q++) begin
            if (q == 31) begin bus.value = 16'h0000; bus.dp = 4'b0100; bus.load = 1'b1; end
            if (q == 32) begin bus.value = 16'hFFFF; bus.dp = 4'b0000; bus.load = 1'b0; end
            tick();
            got = observed();
            exp = q < 32 ? expect_at(q, 16'hABCD, 4'h0) : expect_at(q, 16'h0000, 4'b0100);
            vecs++;
            if (got !== exp) begin errs++; $display("FAIL dp q=%0d got %b required %b", q, got, exp); end
        end
    endtask

    task automatic test_enable;
        logic [12:0] got, exp;
        for (int q = 0; q < 52; q++) begin
            if (q == 10) bus.enable = 1'b0;
            if (q == 11) begin bus.value = 16'h4321; bus.dp = 4'h0; bus.load = 1'b1; end
            if (q == 12) bus.load = 1'b0;
            if (q == 15) bus.enable = 1'b1;
            tick();
            got = observed();
            exp = q < 10 ? expect_at(q, 16'h0000, 4'b0100) : q < 15 ? ALL_OFF : expect_at(q - 15, 16'h4321, 4'h0);
            vecs++;
            if (got !== exp) begin errs++; $display("FAIL enable q=%0d got %b required %b", q, got, exp); end
        end
    endtask

    task automatic test_reset_mid;
        logic [12:0] got, exp;
        #2 rst_n = 1'b0;
        #1 got = observed();
        vecs++;
        if (got !== ALL_OFF) begin errs++; $display("FAIL reset_mid got %b required %b", got, ALL_OFF); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int p = 0; p < 12; p++) begin
            tick();
            got = observed(); exp = expect_at(p, 16'h0000, 4'h0);
            vecs++;
            if (got !== exp) begin errs++; $display("FAIL restart p=%0d got %b required %b", p, got, exp); end
        end
    endtask

    task automatic test_leading_zero;
        logic [12:0] got, exp;
        bus.enable = 1'b0; bus.value = 16'h0042; bus.dp = 4'h0; bus.load = 1'b1;
        tick();
        got = observed();
        vecs++;
        if (got !== ALL_OFF) begin errs++; $display("FAIL lz_dark got %b required %b", got, ALL_OFF); end
        bus.enable = 1'b1; bus.load = 1'b0;
        for (int p = 0; p < 32; p++) begin
            tick();
            got = observed(); exp = expect_at(p, 16'h0042, 4'h0);
            vecs++;
            if (got !== exp) begin errs++; $display("FAIL leading_zero p=%0d got %b required %b", p, got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_dp_wrap_load();
        test_enable();
        test_reset_mid();
        test_leading_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display: one shared segment bus, one active-low select line per digit.
- Holds a tear-free shadow copy of the displayed hex value and scans digits at a programmable rate.
- Inserts an anode-off blanking gap at the start of each digit slot to suppress ghosting.
- Sits between the datapath (value/dp producer) and the board display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned (1..16).
- CLK_DIV, 50000, clock cycles per digit slot (>= BLANK_CYCLES+1).
- BLANK_CYCLES, 64, cycles at the start of each slot with every anode off (0 allowed).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  scan enable; low = display dark.
- value  in  4*N_DIGITS  hex digits; value[4i+3:4i] drives digit i (digit 0 = least significant).
- dp  in  N_DIGITS  decimal point per digit, 1 = lit.
- load  in  1  strobe: capture value/dp into the pending register.
- display_pins  out  8  segments {a,b,c,d,e,f,g,dp} at bits 7..0, 0 = lit.
- digit_sel  out  N_DIGITS  anode selects, one-hot-low, 1 = off.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.

Behaviour:
- Reset (async, rst_n=0): display_pins=8'hFF, digit_sel all 1, frame_start=0, slot counter=0, digit index=0, shadow/pending=0, pending_valid=0.
- Registers: slot counter (0..CLK_DIV-1), digit index (0..N_DIGITS-1), pending {value,dp,valid}, shadow {value,dp}.
- All outputs are registered. Outputs at cycle k+1 reflect counter/index/shadow at cycle k.
- FSM per slot:
  - BLANK while counter < BLANK_CYCLES: digit_sel all 1, display_pins=8'hFF.
  - SHOW for the remaining cycles: digit_sel[index]=0, others 1; display_pins = decode(shadow nibble[index]) with bit0 cleared if shadow dp[index]=1.
- Decode table, hex 0..F (bits 7..0):
  - 0 00000011, 1 10011111, 2 00100101, 3 00001101
  - 4 10011001, 5 01001001, 6 01000001, 7 00011111
  - 8 00000001, 9 00001001, A 00010001, b 11000001
  - C 01100011, d 10000101, E 01100001, F 01110001
- Slot end (counter = CLK_DIV-1): counter -> 0; index increments. Index wraps N_DIGITS-1 -> 0; N_DIGITS=1 wraps every slot.
- frame_start asserts for the one cycle in which the outputs first reflect counter=0, index=0.
- load=1: pending <= {value,dp}, pending_valid <= 1. A later load before commit overwrites.
- Commit (shadow <= pending, pending_valid <= 0) happens only on the wrap to index 0, so no frame ever mixes old and new digits.
- load coincident with wrap: the new value is committed directly.
- enable=0: next cycle outputs all-off, counter/index forced to 0, pending committed immediately. Loads are still accepted.
- enable rising: scan restarts at digit 0, BLANK phase, frame_start pulses.
- Reset mid-slot: outputs go off immediately (asynchronous). Scan restarts from digit 0 after release.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: digits above the most significant nonzero nibble with dp=0 are leading zeros. In their SHOW phase, digit_sel stays all 1 and display_pins=8'hFF. Digit 0 is never blanked.
- Undefined: every digit is shown, including leading zeros.

Decomposition:
- Package seg_pkg: 16-entry segment pattern constant array, SEG_OFF=8'hFF, DP_BIT=0, state enum {BLANK, SHOW}.
- Sub-module seg_decode: combinational nibble+dp -> 8-bit pattern, instantiated once on the muxed nibble.

Test Plan:
- Reset: rst_n low mid-scan -> display_pins=8'hFF, digit_sel=4'hF, frame_start=0 within the same cycle, no clock edge needed.
- Scan: N_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2, load 16'h1234.
  - Digit-0 slot: 2 cycles digit_sel=4'hF, then 6 cycles digit_sel=4'hE with display_pins=8'b10011001.
  - Digits 1..3 in order: 1110 -> 1101 -> 1011 -> 0111.
  - frame_start every 32 cycles.
- Tear-free load: load 16'hABCD during digit-2 slot -> digit 3 still shows 1 (8'b10011111); next frame shows D/C/b/A.
- DP: dp=4'b0100 with value 16'h0000 -> digit 2 shows 8'b00000010, others 8'b00000011.
- Enable: drop enable for 5 cycles mid digit-1 -> outputs off next cycle; restore -> digit 0 BLANK, frame_start pulse.
- SEG_LEADING_ZERO_BLANK_EN defined: value 16'h0042, dp=0 -> digits 3,2 never selected; digit 1=4, digit 0=2 (8'b00100101).
